// File: rtl/uart_sample_streamer_pkg.sv
// Shared types and constants for the UART sample streamer.
// The header option is selected with the UART_SYNC_HEADER_EN macro.
package uart_stream_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } ser_state_e;

    localparam int unsigned FrameBits       = 10;
    localparam logic [7:0]  SyncByteDefault = 8'hA5;

    function automatic int unsigned bytes_for(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_sample_streamer_if.sv
// Sample push handshake between the capture path (master) and the streamer (slave).
interface uart_sample_streamer_if #(
    parameter int unsigned DATA_W = 22
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              new_frame;

    modport master (output i_valid, output i_data, output new_frame);
    modport slave  (input  i_valid, input  i_data, input  new_frame);
endinterface

// File: rtl/uart_sample_streamer_fifo.sv
// Synchronous FIFO for the sample streamer; no write-to-read bypass.
module sample_fifo #(
    parameter int unsigned Width = 23,
    parameter int unsigned Depth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       drop_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = (count_q == CntW'(Depth));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a push while full still lands.
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && !do_push;

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign fill_o  = count_q;

endmodule

// File: rtl/uart_sample_streamer.sv
// Buffers samples and sends each as ceil(DATA_W/8) 8N1 bytes, LSB byte first.
// Define UART_SYNC_HEADER_EN to prefix frame-tagged samples with SYNC_BYTE.
module uart_sample_streamer
    import uart_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = 22,
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic                       sys_clock,
    input  logic                       reset,
    input  logic                       UART_send,
    input  logic                       clear_ovf,
    uart_sample_streamer_if.slave      push_if,
    output logic                       UART_TX,
    output logic [$clog2(DEPTH+1)-1:0] o_fill,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic                       o_busy
);
    localparam int unsigned Bytes = bytes_for(DATA_W);
    localparam int unsigned WordW = Bytes * 8;

`ifdef UART_SYNC_HEADER_EN
    localparam int unsigned FifoW = DATA_W + 1;
`else
    localparam int unsigned FifoW = DATA_W;
`endif

    logic [FifoW-1:0] fifo_wdata, fifo_rdata;
    logic             fifo_pop, fifo_drop, word_tag;

`ifdef UART_SYNC_HEADER_EN
    assign fifo_wdata = {push_if.new_frame, push_if.i_data};
    assign word_tag   = fifo_rdata[DATA_W];
`else
    logic unused_new_frame;
    assign unused_new_frame = push_if.new_frame;
    assign fifo_wdata       = push_if.i_data;
    assign word_tag         = 1'b0;
`endif

    sample_fifo #(
        .Width (FifoW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clock),
        .rst_i   (reset),
        .push_i  (push_if.i_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .fill_o  (o_fill),
        .full_o  (o_full),
        .empty_o (o_empty),
        .drop_o  (fifo_drop)
    );

    ser_state_e       state_q, state_d;
    logic             loaded_q, loaded_d;
    logic             hdr_q, hdr_d;
    logic [WordW-1:0] word_q, word_d;
    logic [2:0]       bytes_left_q, bytes_left_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cur_byte_d;

    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        hdr_d        = hdr_q;
        word_d       = word_q;
        bytes_left_d = bytes_left_q;
        bit_idx_d    = bit_idx_q;
        fifo_pop     = 1'b0;

        if (state_q == StIdle && !loaded_q && !o_empty) begin
            fifo_pop                = 1'b1;
            loaded_d                = 1'b1;
            word_d                  = '0;
            word_d[DATA_W-1:0]      = fifo_rdata[DATA_W-1:0];
            hdr_d                   = word_tag;
            bytes_left_d            = 3'(Bytes);
        end

        if (UART_send) begin
            unique case (state_q)
                StIdle: begin
                    if (loaded_q) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
                StData: begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                StStop: begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = StStart;
                    end else if (bytes_left_q == 3'd1) begin
                        state_d  = StIdle;
                        loaded_d = 1'b0;
                    end else begin
                        bytes_left_d = bytes_left_q - 3'd1;
                        word_d       = word_q >> 8;
                        state_d      = StStart;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // TX is registered alongside the state so the line always mirrors state_q.
        cur_byte_d = hdr_d ? SYNC_BYTE : word_d[7:0];
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase

        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q      <= StIdle;
            loaded_q     <= 1'b0;
            hdr_q        <= 1'b0;
            word_q       <= '0;
            bytes_left_q <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            hdr_q        <= hdr_d;
            word_q       <= word_d;
            bytes_left_q <= bytes_left_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            ovf_q        <= ovf_d;
        end
    end

    assign UART_TX    = tx_q;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q != StIdle) || loaded_q;

endmodule

// File: tb/tb_uart_sample_streamer.sv
// Directed bench: main DUT (22-bit, depth 4) plus 8- and 32-bit width instances.
module tb_uart_sample_streamer;
    import uart_stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, send, clear_ovf;

    uart_sample_streamer_if #(.DATA_W(22)) if_m  ();
    uart_sample_streamer_if #(.DATA_W(8))  if_8  ();
    uart_sample_streamer_if #(.DATA_W(32)) if_32 ();

    logic       tx_m, full_m, empty_m, ovf_m, busy_m;
    logic [2:0] fill_m;
    logic       tx_8, full_8, empty_8, ovf_8, busy_8;
    logic [4:0] fill_8;
    logic       tx_32, full_32, empty_32, ovf_32, busy_32;
    logic [4:0] fill_32;

    uart_sample_streamer #(.DATA_W(22), .DEPTH(4)) dut (
        .sys_clock (clk), .reset (reset), .UART_send (send), .clear_ovf (clear_ovf),
        .push_if (if_m), .UART_TX (tx_m), .o_fill (fill_m), .o_full (full_m),
        .o_empty (empty_m), .o_overflow (ovf_m), .o_busy (busy_m)
    );

    uart_sample_streamer #(.DATA_W(8), .DEPTH(16)) dut8 (
        .sys_clock (clk), .reset (reset), .UART_send (send), .clear_ovf (clear_ovf),
        .push_if (if_8), .UART_TX (tx_8), .o_fill (fill_8), .o_full (full_8),
        .o_empty (empty_8), .o_overflow (ovf_8), .o_busy (busy_8)
    );

    uart_sample_streamer #(.DATA_W(32), .DEPTH(16)) dut32 (
        .sys_clock (clk), .reset (reset), .UART_send (send), .clear_ovf (clear_ovf),
        .push_if (if_32), .UART_TX (tx_32), .o_fill (fill_32), .o_full (full_32),
        .o_empty (empty_32), .o_overflow (ovf_32), .o_busy (busy_32)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int gap      = 3;

    function automatic logic pick_tx(input int sel);
        case (sel)
            1:       return tx_8;
            2:       return tx_32;
            default: return tx_m;
        endcase
    endfunction

    task automatic strobe();
        @(negedge clk) send = 1'b1;
        @(negedge clk) send = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push(input int sel, input logic [31:0] d, input logic nf);
        @(negedge clk);
        case (sel)
            1: begin if_8.i_valid = 1'b1; if_8.i_data = d[7:0]; if_8.new_frame = nf; end
            2: begin if_32.i_valid = 1'b1; if_32.i_data = d; if_32.new_frame = nf; end
            default: begin if_m.i_valid = 1'b1; if_m.i_data = d[21:0]; if_m.new_frame = nf; end
        endcase
        @(negedge clk);
        if_m.i_valid = 1'b0; if_8.i_valid = 1'b0; if_32.i_valid = 1'b0;
        if_m.new_frame = 1'b0; if_8.new_frame = 1'b0; if_32.new_frame = 1'b0;
    endtask

    task automatic read_frame(input int sel, output logic [7:0] b, output int ferr);
        logic t;
        ferr = 0;
        b    = '0;
        for (int i = 0; i < FrameBits; i++) begin
            strobe();
            t = pick_tx(sel);
            if (i == 0) begin
                if (t !== 1'b0) ferr++;
            end else if (i == FrameBits - 1) begin
                if (t !== 1'b1) ferr++;
            end else begin
                b[i-1] = t;
            end
        end
    endtask

    task automatic read_word(input int sel, input int nbytes, output logic [39:0] val,
                             output int ferr);
        logic [7:0] b;
        int         fe;
        val  = '0;
        ferr = 0;
        for (int k = 0; k < nbytes; k++) begin
            read_frame(sel, b, fe);
            val[k*8 +: 8] = b;
            ferr += fe;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (tx_m !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_m); end
        n_checks++; if (fill_m !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_m); end
        n_checks++; if (full_m !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full_m); end
        n_checks++; if (empty_m !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty_m); end
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_m); end
        n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    endtask

    task automatic test_single_word();
        logic [39:0] v;
        int          fe;
        gap = 62;
        push(0, 32'h0F0F0F, 1'b0);
        n_checks++; if (fill_m !== 3'd1) begin n_fail++; $display("FAIL single_fill: got %0d expected 1", fill_m); end
        @(negedge clk);
        n_checks++; if (busy_m !== 1'b1 || fill_m !== 3'd0) begin
            n_fail++; $display("FAIL single_load: busy %b fill %0d expected busy 1 fill 0", busy_m, fill_m); end
        read_word(0, 3, v, fe);
        n_checks++; if (v !== 40'h0F0F0F || fe !== 0) begin
            n_fail++; $display("FAIL single_word: got %h ferr %0d expected 0f0f0f ferr 0", v, fe); end
        strobe();
        n_checks++; if (tx_m !== 1'b1 || empty_m !== 1'b1 || busy_m !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: tx %b empty %b busy %b expected 1 1 0", tx_m, empty_m, busy_m); end
        gap = 3;
    endtask

    task automatic test_overfill();
        logic [39:0] v;
        int          fe;
        for (int n = 1; n <= 6; n++) push(0, 32'(n), 1'b0);
        n_checks++; if (fill_m !== 3'd4 || full_m !== 1'b1 || ovf_m !== 1'b1) begin
            n_fail++; $display("FAIL overfill_status: fill %0d full %b ovf %b expected 4 1 1", fill_m, full_m, ovf_m); end
        // Word 1 was already moved into the shifter, so five samples survive.
        for (int n = 1; n <= 5; n++) begin
            read_word(0, 3, v, fe);
            n_checks++; if (v !== 40'(n) || fe !== 0) begin
                n_fail++; $display("FAIL overfill_drain%0d: got %h ferr %0d expected %h", n, v, fe, 40'(n)); end
            strobe();
        end
        n_checks++; if (empty_m !== 1'b1 || busy_m !== 1'b0 || ovf_m !== 1'b1) begin
            n_fail++; $display("FAIL overfill_after: empty %b busy %b ovf %b expected 1 0 1", empty_m, busy_m, ovf_m); end
        @(negedge clk) clear_ovf = 1'b1;
        @(negedge clk) clear_ovf = 1'b0;
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL overfill_clear: got %b expected 0", ovf_m); end
    endtask

    task automatic test_full_boundary();
        logic [39:0] v;
        int          fe;
        logic [39:0] exp_v [5];
        for (int n = 10; n <= 14; n++) push(0, 32'(n), 1'b0);
        n_checks++; if (fill_m !== 3'd4 || full_m !== 1'b1) begin
            n_fail++; $display("FAIL boundary_prefill: fill %0d full %b expected 4 1", fill_m, full_m); end
        read_word(0, 3, v, fe);
        n_checks++; if (v !== 40'd10 || fe !== 0) begin
            n_fail++; $display("FAIL boundary_first: got %h ferr %0d expected 0a", v, fe); end
        // Strobe to IDLE, then push in the very cycle the pop happens.
        @(negedge clk) send = 1'b1;
        @(negedge clk) begin send = 1'b0; if_m.i_valid = 1'b1; if_m.i_data = 22'd7; end
        @(negedge clk) if_m.i_valid = 1'b0;
        n_checks++; if (fill_m !== 3'd4 || full_m !== 1'b1 || ovf_m !== 1'b0) begin
            n_fail++; $display("FAIL boundary_push: fill %0d full %b ovf %b expected 4 1 0", fill_m, full_m, ovf_m); end
        exp_v[0] = 40'd11; exp_v[1] = 40'd12; exp_v[2] = 40'd13; exp_v[3] = 40'd14; exp_v[4] = 40'd7;
        for (int k = 0; k < 5; k++) begin
            read_word(0, 3, v, fe);
            n_checks++; if (v !== exp_v[k] || fe !== 0) begin
                n_fail++; $display("FAIL boundary_drain%0d: got %h ferr %0d expected %h", k, v, fe, exp_v[k]); end
            strobe();
        end
        n_checks++; if (empty_m !== 1'b1 || busy_m !== 1'b0) begin
            n_fail++; $display("FAIL boundary_end: empty %b busy %b expected 1 0", empty_m, busy_m); end
    endtask

    task automatic test_header();
        logic [39:0] v;
        int          fe;
        push(0, 32'h000001, 1'b1);
        @(negedge clk);
`ifdef UART_SYNC_HEADER_EN
        read_word(0, 4, v, fe);
        n_checks++; if (v !== 40'h00000001A5 || fe !== 0) begin
            n_fail++; $display("FAIL header_bytes: got %h ferr %0d expected 00000001a5", v, fe); end
`else
        read_word(0, 3, v, fe);
        n_checks++; if (v !== 40'h000001 || fe !== 0) begin
            n_fail++; $display("FAIL header_bytes: got %h ferr %0d expected 000001", v, fe); end
`endif
        strobe();
        n_checks++; if (busy_m !== 1'b0 || tx_m !== 1'b1) begin
            n_fail++; $display("FAIL header_idle: busy %b tx %b expected 0 1", busy_m, tx_m); end
    endtask

    task automatic test_reset_mid();
        int bad;
        push(0, 32'h000000, 1'b0);
        @(negedge clk);
        push(0, 32'h000005, 1'b0);
        repeat (5) strobe();
        n_checks++; if (tx_m !== 1'b0 || fill_m !== 3'd1) begin
            n_fail++; $display("FAIL midreset_pre: tx %b fill %0d expected 0 1", tx_m, fill_m); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_checks++; if (tx_m !== 1'b1 || fill_m !== 3'd0 || busy_m !== 1'b0) begin
            n_fail++; $display("FAIL midreset_post: tx %b fill %0d busy %b expected 1 0 0", tx_m, fill_m, busy_m); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            strobe();
            if (tx_m !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d low strobes expected 0", bad); end
    endtask

    task automatic test_width_sweep();
        logic [39:0] v;
        int          fe;
        push(1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        read_word(1, 1, v, fe);
        n_checks++; if (v !== 40'hEF || fe !== 0) begin
            n_fail++; $display("FAIL width8: got %h ferr %0d expected ef", v, fe); end
        strobe();
        n_checks++; if (busy_8 !== 1'b0 || tx_8 !== 1'b1) begin
            n_fail++; $display("FAIL width8_idle: busy %b tx %b expected 0 1", busy_8, tx_8); end
        push(2, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        read_word(2, 4, v, fe);
        n_checks++; if (v !== 40'hDEADBEEF || fe !== 0) begin
            n_fail++; $display("FAIL width32: got %h ferr %0d expected deadbeef", v, fe); end
        strobe();
        n_checks++; if (busy_32 !== 1'b0 || tx_32 !== 1'b1) begin
            n_fail++; $display("FAIL width32_idle: busy %b tx %b expected 0 1", busy_32, tx_32); end
    endtask

    initial begin
        reset = 1'b1; send = 1'b0; clear_ovf = 1'b0;
        if_m.i_valid = 1'b0;  if_m.i_data = '0;  if_m.new_frame = 1'b0;
        if_8.i_valid = 1'b0;  if_8.i_data = '0;  if_8.new_frame = 1'b0;
        if_32.i_valid = 1'b0; if_32.i_data = '0; if_32.new_frame = 1'b0;
        test_reset();
        test_single_word();
        test_overfill();
        test_full_boundary();
        test_header();
        test_reset_mid();
        test_width_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
